if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 16-bit pipeline, directly upstream of ID.
//  - Owns the PC and fetches one 16-bit instruction per handshake from a request/response imem.
//  - Presents a registered instruction and its PC to ID; inserts NOP bubbles when no instruction is ready.
//  - Applies branch redirects reported by ID, discarding wrong-path fetches.
// PARAMETERS
//  PC_W      16       PC / imem address width; word-addressed, one instruction per address
//  RESET_PC  0        PC value loaded on reset
// PORTS
//  clk                in   1     clock
//  rst                in   1     reset, asynchronous, active-high
//  imem_req           out  1     fetch request valid
//  imem_addr          out  PC_W  fetch address (= pc)
//  imem_gnt           in   1     imem accepts request; handshake = req & gnt
//  imem_rvalid        in   1     response valid, >=1 cycle after handshake
//  imem_rdata         in   16    fetched instruction
//  stall              in   1     downstream hazard: hold instr_out/pc_out
//  branch_taken       in   1     ID resolved a taken branch on instr_out
//  branch_offset_imm  in   6     signed branch offset from ID
//  instr_out          out  16    instruction to ID (NOP = 16'h0000)
//  pc_out             out  PC_W  address of instr_out
//  valid_out          out  1     1 = instr_out is a real fetch; 0 = bubble
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=FETCH, skid empty, instr_out=0, pc_out=0, valid_out=0, imem_req=0.
//    Any response still in flight at reset is ignored.
//  - States: FETCH (nothing outstanding), WAIT (one outstanding), DROP (one outstanding, wrong path).
//  - Never more than one request outstanding.
//  - imem_req = !rst & !redirect & !skid_valid & (FETCH | (WAIT & imem_rvalid & !stall)).
//    redirect = branch_taken & !stall.
//  - On handshake: req_pc <= pc; pc <= pc+1 (wraps at 2^PC_W); state -> WAIT.
//  - WAIT & rvalid:
//    - stall=0: instr_out <= rdata, pc_out <= req_pc, valid_out <= 1.
//    - stall=1: skid <= {rdata, req_pc}, skid_valid <= 1.
//    - Then -> FETCH, or stay in WAIT if a new handshake occurs in the same cycle.
//  - Cycle with stall=0, no accepted response, skid empty: instr_out <= 0, valid_out <= 0
//    (bubble; pc_out holds).
//  - stall=0 & skid_valid: instr_out/pc_out <= skid, valid_out <= 1, skid_valid <= 0.
//    A skid is only filled while the stage has no room, so a skid and a response never coincide.
//  - stall=1: instr_out/pc_out/valid_out hold; branch_taken is ignored.
//  - redirect: pc <= pc_out + 1 + sext(branch_offset_imm), modulo 2^PC_W.
//    Same cycle: instr_out <= 0, valid_out <= 0, skid_valid <= 0.
//    State: WAIT -> DROP (or -> FETCH if rvalid is also high that cycle; that response is dropped).
//    No request is issued in the redirect cycle.
//  - DROP: rdata is discarded on rvalid -> FETCH. A second redirect in DROP only updates pc.
//  - rvalid in FETCH (no outstanding request) is ignored.
//  - Latency: handshake at cycle N, rvalid at N+k -> instr_out visible at N+k+1.
//    Peak rate 1 instruction/cycle when k=1 and gnt=1.
// STRUCTURE
//  - Shared package (pipe_pkg):
//    - INSTR_W=16, NOP_INSTR=16'h0000
//    - if_state_t {FETCH, WAIT, DROP}
//    - function sext6(imm6) -> PC_W
//  - Sub-module if_skid_buf: 1-entry {instr, pc} holding register with load/clear/valid.
//  - FSM, PC and redirect logic stay in if_stage.
// TESTING
//  1. Reset, gnt=1, 1-cycle memory returning rdata=addr|16'h1000, stall=0 ->
//     imem_addr 0,1,2,... on consecutive cycles; instr_out 1000,1001,... one per cycle,
//     pc_out matches; valid_out=1 from the 3rd cycle.
//  2. gnt held 0 for 3 cycles after reset ->
//     imem_req stays 1, imem_addr=0, instr_out=0, valid_out=0 throughout; fetch resumes when gnt=1.
//  3. stall=1 for 2 cycles while instr_out=1003 and a response 1004 returns ->
//     instr_out holds 1003, 1004 goes to skid, no new request;
//     after stall drops, instr_out=1004 next cycle, then fetch at 5.
//  4. branch_taken=1, imm=6'h3E (-2), pc_out=5 ->
//     next pc=4; instr_out=0, valid_out=0; in-flight response for 6 is discarded;
//     next handshake addr=4.
//  5. branch_taken=1 together with stall=1 -> no redirect; pc and outputs unchanged.
//  6. Assert rst while in WAIT, then release; memory returns the old response ->
//     all outputs reset to 0; the stale rvalid is ignored; first post-reset fetch addr=RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the 16-bit pipeline.
package pipe_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;
    localparam int unsigned IMM_W   = 6;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } if_state_t;

    // Sign-extend the 6-bit branch immediate reported by ID.
    function automatic logic [PC_W-1:0] sext6(input logic [IMM_W-1:0] imm);
        return {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: imem request/response channel plus the ID-facing side.
interface if_stage_if #(
    parameter int unsigned PC_W = 16
);
    import pipe_pkg::*;

    logic                imem_req;
    logic [PC_W-1:0]     imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [INSTR_W-1:0]  imem_rdata;

    logic                stall;
    logic                branch_taken;
    logic [IMM_W-1:0]    branch_offset_imm;

    logic [INSTR_W-1:0]  instr_out;
    logic [PC_W-1:0]     pc_out;
    logic                valid_out;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  stall, branch_taken, branch_offset_imm,
        output instr_out, pc_out, valid_out
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output stall, branch_taken, branch_offset_imm,
        input  instr_out, pc_out, valid_out
    );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc} holding register for a response that arrives while ID is stalled.
module if_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned PC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    // Load wins over clear; the stage never requests both in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from imem, feeds ID, applies branch redirects.
module if_stage
    import pipe_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);

    if_state_t state_q, state_d;

    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    req_pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_out_q;
    logic               valid_q;

    logic               redirect;
    logic               resp_ok;
    logic               fetch_req;
    logic               hs;
    logic [PC_W-1:0]    target_pc;

    logic               skid_load;
    logic               skid_clear;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    // A response is only usable when it answers a live (non-wrong-path) request.
    assign redirect  = bus.branch_taken & ~bus.stall;
    assign resp_ok   = (state_q == WAIT) & bus.imem_rvalid;
    assign fetch_req = ~rst & ~redirect & ~skid_valid &
                       ((state_q == FETCH) | (resp_ok & ~bus.stall));
    assign hs        = fetch_req & bus.imem_gnt;
    assign target_pc = pc_out_q + PC_W'(1) +
                       PC_W'(signed'(sext6(bus.branch_offset_imm)));

    assign skid_load  = resp_ok & bus.stall;
    assign skid_clear = redirect | (~bus.stall & skid_valid);

    if_skid_buf #(
        .PC_W (PC_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .clear    (skid_clear),
        .instr_in (bus.imem_rdata),
        .pc_in    (req_pc_q),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // At most one request outstanding; DROP swallows the response of a squashed fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (hs) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = hs ? WAIT : FETCH;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // PC and request bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            if (redirect) begin
                pc_q <= target_pc;
            end else if (hs) begin
                pc_q <= pc_q + PC_W'(1);
            end
            if (hs) begin
                req_pc_q <= pc_q;
            end
        end
    end

    // ID-facing registers: skid first, then a fresh response, otherwise a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else if (redirect) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (!bus.stall) begin
            if (skid_valid) begin
                instr_q  <= skid_instr;
                pc_out_q <= skid_pc;
                valid_q  <= 1'b1;
            end else if (resp_ok) begin
                instr_q  <= bus.imem_rdata;
                pc_out_q <= req_pc_q;
                valid_q  <= 1'b1;
            end else begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.imem_req  = fetch_req;
    assign bus.imem_addr = pc_q;
    assign bus.instr_out = instr_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a small latency-programmable imem model.
module tb_if_stage;

    bit          clk = 1'b0;
    bit          rst = 1'b1;
    bit          gnt = 1'b1;
    bit          stall = 1'b0;
    bit          br = 1'b0;
    logic [5:0]  imm = 6'h00;
    int          mem_lat = 1;

    bit          m_rvalid = 1'b0;
    logic [15:0] m_rdata = 16'h0000;
    bit          m_pend = 1'b0;
    logic [15:0] m_addr = 16'h0000;
    int          m_cnt = 0;

    int total = 0;
    int bad = 0;

    if_stage_if #(.PC_W(16)) bus ();

    if_stage #(
        .PC_W     (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_gnt          = gnt;
    assign bus.imem_rvalid       = m_rvalid;
    assign bus.imem_rdata        = m_rdata;
    assign bus.stall             = stall;
    assign bus.branch_taken      = br;
    assign bus.branch_offset_imm = imm;

    always #5 clk = ~clk;

    // imem model: answers addr|0x1000 mem_lat cycles after the handshake; never reset.
    always @(posedge clk) begin
        m_rvalid <= 1'b0;
        if (m_pend) begin
            if (m_cnt == 1) begin
                m_rvalid <= 1'b1;
                m_rdata  <= m_addr | 16'h1000;
                m_pend   <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
        if (bus.imem_req && bus.imem_gnt) begin
            if (mem_lat == 1) begin
                m_rvalid <= 1'b1;
                m_rdata  <= bus.imem_addr | 16'h1000;
            end else begin
                m_pend <= 1'b1;
                m_addr <= bus.imem_addr;
                m_cnt  <= mem_lat - 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.instr_out !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", bus.instr_out); end
        total++; if (bus.pc_out !== 16'h0000) begin bad++; $display("FAIL reset_pc_out: got %h want 0000", bus.pc_out); end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        rst = 1'b0;
    endtask

    // Cycles 0..5 after reset release: one fetch per cycle.
    task automatic test_stream();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL stream_req c%0d: got %b want 1", c, bus.imem_req); end
            total++; if (bus.imem_addr !== 16'(c)) begin bad++; $display("FAIL stream_addr c%0d: got %h want %h", c, bus.imem_addr, 16'(c)); end
            if (c >= 2) begin
                total++; if (bus.instr_out !== 16'h1000 + 16'(c - 2)) begin bad++; $display("FAIL stream_instr c%0d: got %h want %h", c, bus.instr_out, 16'h1000 + 16'(c - 2)); end
                total++; if (bus.pc_out !== 16'(c - 2)) begin bad++; $display("FAIL stream_pc c%0d: got %h want %h", c, bus.pc_out, 16'(c - 2)); end
                total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL stream_valid c%0d: got %b want 1", c, bus.valid_out); end
            end else begin
                total++; if (bus.instr_out !== 16'h0000) begin bad++; $display("FAIL stream_bubble c%0d: got %h want 0000", c, bus.instr_out); end
                total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL stream_bubble_v c%0d: got %b want 0", c, bus.valid_out); end
            end
        end
    endtask

    // Cycle 5: stall while 1003 shown and 1004 returns; stall held for cycles 5,6.
    task automatic test_stall_skid();
        stall = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req5: got %b want 0", bus.imem_req); end
        @(negedge clk); #1;
        total++; if (bus.instr_out !== 16'h1003) begin bad++; $display("FAIL stall_hold6: got %h want 1003", bus.instr_out); end
        total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL stall_valid6: got %b want 1", bus.valid_out); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req6: got %b want 0", bus.imem_req); end
        @(negedge clk); stall = 1'b0; #1;
        total++; if (bus.instr_out !== 16'h1003) begin bad++; $display("FAIL stall_hold7: got %h want 1003", bus.instr_out); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL skid_drain_req7: got %b want 0", bus.imem_req); end
        @(negedge clk); #1;
        total++; if (bus.instr_out !== 16'h1004) begin bad++; $display("FAIL skid_instr8: got %h want 1004", bus.instr_out); end
        total++; if (bus.pc_out !== 16'h0004) begin bad++; $display("FAIL skid_pc8: got %h want 0004", bus.pc_out); end
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0005) begin bad++; $display("FAIL refetch8: got req=%b addr=%h want req=1 addr=0005", bus.imem_req, bus.imem_addr); end
    endtask

    // Redirect from pc_out=5 with imm=-2 while the fetch of 6 is in flight.
    task automatic test_branch();
        @(negedge clk); mem_lat = 2; #1;
        total++; if (bus.valid_out !== 1'b0 || bus.instr_out !== 16'h0000) begin bad++; $display("FAIL bubble9: got instr=%h v=%b want 0000/0", bus.instr_out, bus.valid_out); end
        total++; if (bus.imem_addr !== 16'h0006) begin bad++; $display("FAIL addr9: got %h want 0006", bus.imem_addr); end
        @(negedge clk); mem_lat = 1; br = 1'b1; imm = 6'h3E; #1;
        total++; if (bus.instr_out !== 16'h1005 || bus.pc_out !== 16'h0005) begin bad++; $display("FAIL pre_branch10: got %h@%h want 1005@0005", bus.instr_out, bus.pc_out); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL branch_noreq10: got %b want 0", bus.imem_req); end
        @(negedge clk); br = 1'b0; #1;
        total++; if (bus.instr_out !== 16'h0000 || bus.valid_out !== 1'b0) begin bad++; $display("FAIL branch_flush11: got %h v=%b want 0000/0", bus.instr_out, bus.valid_out); end
        total++; if (bus.imem_addr !== 16'h0004) begin bad++; $display("FAIL branch_target11: got %h want 0004", bus.imem_addr); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL drop_noreq11: got %b want 0", bus.imem_req); end
        @(negedge clk); #1;
        total++; if (bus.instr_out !== 16'h0000 || bus.valid_out !== 1'b0) begin bad++; $display("FAIL drop_discard12: got %h v=%b want 0000/0", bus.instr_out, bus.valid_out); end
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0004) begin bad++; $display("FAIL refetch12: got req=%b addr=%h want 1/0004", bus.imem_req, bus.imem_addr); end
        @(negedge clk); #1;
        total++; if (bus.imem_addr !== 16'h0005) begin bad++; $display("FAIL addr13: got %h want 0005", bus.imem_addr); end
    endtask

    // Branch together with stall must be ignored; response of 5 goes to skid.
    task automatic test_branch_stall();
        @(negedge clk); stall = 1'b1; br = 1'b1; imm = 6'h3E; #1;
        total++; if (bus.instr_out !== 16'h1004 || bus.pc_out !== 16'h0004 || bus.valid_out !== 1'b1) begin bad++; $display("FAIL target_instr14: got %h@%h v=%b want 1004@0004/1", bus.instr_out, bus.pc_out, bus.valid_out); end
        @(negedge clk); #1;
        total++; if (bus.instr_out !== 16'h1004 || bus.pc_out !== 16'h0004) begin bad++; $display("FAIL bs_hold15: got %h@%h want 1004@0004", bus.instr_out, bus.pc_out); end
        total++; if (bus.imem_addr !== 16'h0006) begin bad++; $display("FAIL bs_pc15: got %h want 0006", bus.imem_addr); end
        @(negedge clk); stall = 1'b0; br = 1'b0; #1;
        total++; if (bus.instr_out !== 16'h1004 || bus.valid_out !== 1'b1) begin bad++; $display("FAIL bs_hold16: got %h v=%b want 1004/1", bus.instr_out, bus.valid_out); end
        @(negedge clk); #1;
        total++; if (bus.instr_out !== 16'h1005 || bus.pc_out !== 16'h0005) begin bad++; $display("FAIL bs_skid17: got %h@%h want 1005@0005", bus.instr_out, bus.pc_out); end
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0006) begin bad++; $display("FAIL bs_fetch17: got req=%b addr=%h want 1/0006", bus.imem_req, bus.imem_addr); end
    endtask

    // Reset mid-stream, then hold gnt low for three cycles.
    task automatic test_gnt_low();
        @(negedge clk); gnt = 1'b0; rst = 1'b1; #1;
        total++; if (bus.instr_out !== 16'h0000 || bus.pc_out !== 16'h0000 || bus.valid_out !== 1'b0) begin bad++; $display("FAIL async_rst: got %h@%h v=%b want 0000@0000/0", bus.instr_out, bus.pc_out, bus.valid_out); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL async_rst_req: got %b want 0", bus.imem_req); end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin bad++; $display("FAIL gnt_low_req c%0d: got req=%b addr=%h want 1/0000", c, bus.imem_req, bus.imem_addr); end
            total++; if (bus.instr_out !== 16'h0000 || bus.valid_out !== 1'b0) begin bad++; $display("FAIL gnt_low_out c%0d: got %h v=%b want 0000/0", c, bus.instr_out, bus.valid_out); end
        end
        @(negedge clk); gnt = 1'b1; #1;
        total++; if (bus.imem_addr !== 16'h0000) begin bad++; $display("FAIL gnt_resume3: got %h want 0000", bus.imem_addr); end
        @(negedge clk); #1;
        total++; if (bus.imem_addr !== 16'h0001) begin bad++; $display("FAIL gnt_resume4: got %h want 0001", bus.imem_addr); end
        @(negedge clk); #1;
        total++; if (bus.instr_out !== 16'h1000 || bus.pc_out !== 16'h0000 || bus.valid_out !== 1'b1) begin bad++; $display("FAIL gnt_first5: got %h@%h v=%b want 1000@0000/1", bus.instr_out, bus.pc_out, bus.valid_out); end
    endtask

    // Reset while a slow fetch is outstanding; its late response must be ignored.
    task automatic test_reset_in_wait();
        @(negedge clk); mem_lat = 3; #1;
        total++; if (bus.instr_out !== 16'h1001) begin bad++; $display("FAIL rw_pre6: got %h want 1001", bus.instr_out); end
        @(negedge clk); rst = 1'b1; gnt = 1'b0; #1;
        total++; if (bus.instr_out !== 16'h0000 || bus.valid_out !== 1'b0 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL rw_rst7: got %h v=%b req=%b want 0000/0/0", bus.instr_out, bus.valid_out, bus.imem_req); end
        @(negedge clk); rst = 1'b0; #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin bad++; $display("FAIL rw_req8: got req=%b addr=%h want 1/0000", bus.imem_req, bus.imem_addr); end
        @(negedge clk); #1;
        total++; if (bus.valid_out !== 1'b0 || bus.imem_addr !== 16'h0000) begin bad++; $display("FAIL rw_stale9: got v=%b addr=%h want 0/0000", bus.valid_out, bus.imem_addr); end
        @(negedge clk); mem_lat = 1; gnt = 1'b1; #1;
        total++; if (bus.instr_out !== 16'h0000 || bus.valid_out !== 1'b0) begin bad++; $display("FAIL rw_ignored10: got %h v=%b want 0000/0", bus.instr_out, bus.valid_out); end
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin bad++; $display("FAIL rw_first_fetch10: got req=%b addr=%h want 1/0000", bus.imem_req, bus.imem_addr); end
        @(negedge clk); #1;
        @(negedge clk); #1;
        total++; if (bus.instr_out !== 16'h1000 || bus.pc_out !== 16'h0000 || bus.valid_out !== 1'b1) begin bad++; $display("FAIL rw_first12: got %h@%h v=%b want 1000@0000/1", bus.instr_out, bus.pc_out, bus.valid_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_skid();
        test_branch();
        test_branch_stall();
        test_gnt_low();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
